// File: rtl/serial_debug_fmt.sv
// Message-to-UART formatter: latches a multi-byte payload and sends it as raw or ASCII-hex
// characters, optionally followed by CR/LF, with a per-character flow-control hold.
module serial_debug_fmt #(
    parameter int CLK_PER_BIT = 434,
    parameter int MSG_LEN     = 4,
    parameter int HEX_MODE    = 0,
    parameter int TERM        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 block,
    input  logic                 send,
    input  logic [8*MSG_LEN-1:0] data,
    output logic                 busy,
    output logic                 tx,
    output logic                 done,
    output logic [2:0]           state_dbg
);
    localparam int NCHAR = MSG_LEN * ((HEX_MODE != 0) ? 2 : 1) + ((TERM != 0) ? 2 : 0);
    localparam int IW    = $clog2(NCHAR + 1);
    localparam int CW    = $clog2(CLK_PER_BIT);

    localparam logic [IW-1:0] LAST_IDX = IW'(NCHAR - 1);
    localparam logic [IW-1:0] CR_IDX   = IW'(NCHAR - 2);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HOLD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [2:0]           state;
    logic [8*MSG_LEN-1:0] shadow;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        byte_idx;
    logic [CW-1:0]        cyc;
    logic [2:0]           bitn;
    logic [7:0]           shreg;
    logic [7:0]           cur_byte;
    logic [3:0]           nib;
    logic [7:0]           hex_char;
    logic [7:0]           char_sel;

    assign state_dbg = state;

    // Character for the current index, derived from the shadow copy so the caller's
    // data bus is free to change once the request has been taken.
    always_comb begin
        byte_idx = (HEX_MODE != 0) ? (idx >> 1) : idx;
        cur_byte = 8'((shadow << {byte_idx, 3'b000}) >> (8 * MSG_LEN - 8));
        nib      = idx[0] ? cur_byte[3:0] : cur_byte[7:4];
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        char_sel = (HEX_MODE != 0) ? hex_char : cur_byte;
        if (TERM != 0 && idx == CR_IDX)
            char_sel = 8'h0D;
        if (TERM != 0 && idx == LAST_IDX)
            char_sel = 8'h0A;
    end

    // Request handshake: send is taken only on an edge where busy is low; busy then stays
    // high until the edge ending the last stop bit, which also pulses done for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tx     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            cyc    <= '0;
            bitn   <= '0;
            idx    <= '0;
            shreg  <= '0;
            shadow <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (send) begin
                        shadow <= data;
                        busy   <= 1'b1;
                        idx    <= '0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    tx <= 1'b1;
                    if (!block) begin
                        shreg <= char_sel;
                        tx    <= 1'b0;
                        cyc   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cyc == BIT_LAST) begin
                        cyc   <= '0;
                        bitn  <= '0;
                        tx    <= shreg[0];
                        state <= DATA;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc == BIT_LAST) begin
                        cyc <= '0;
                        if (bitn == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitn  <= bitn + 1'b1;
                            tx    <= shreg[1];
                            shreg <= shreg >> 1;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                STOP: begin
                    if (cyc == BIT_LAST) begin
                        cyc <= '0;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= HOLD;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_debug_fmt.md
SERIAL_DEBUG_FMT -- requirements
Module: serial_debug_fmt

Interface
REQ-001 Parameter CLK_PER_BIT, default 434, clock cycles per UART bit; legal range >= 2.
REQ-002 Parameter MSG_LEN, default 4, message length in bytes; legal range 1..16.
REQ-003 Parameter HEX_MODE, default 0.
  - 0: each byte is sent raw.
  - 1: each byte is sent as two ASCII hex characters.
REQ-004 Parameter TERM, default 0. When 1, CR (0x0D) then LF (0x0A) are appended after the message.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 block  input  1  flow-control hold; when high, no new character may start.
REQ-009 send  input  1  request to transmit data; sampled each clk edge.
REQ-010 data  input  8*MSG_LEN  message payload; most significant byte is sent first.
REQ-011 busy  output  1  high from request acceptance until the last stop bit completes.
REQ-012 tx  output  1  UART serial line; idles high.
REQ-013 done  output  1  one-cycle pulse when the message has finished.

Function
REQ-014 Request acceptance: send=1 with busy=0 at an edge accepts the request.
  - data is latched into an internal shadow register on that edge.
  - busy goes 1 on that same edge.
REQ-015 While busy=1, send is ignored and data changes have no effect on the message in flight.
REQ-016 Character count: N = MSG_LEN*(HEX_MODE?2:1) + (TERM?2:0); character index counts 0..N-1 with no wrap.
REQ-017 Byte order: byte i is data[8*(MSG_LEN-i)-1 -: 8] for i=0..MSG_LEN-1.
REQ-018 HEX_MODE=1 encoding:
  - each byte gives its upper nibble character first, then its lower nibble character;
  - nibble 0-9 maps to 0x30-0x39;
  - nibble A-F maps to 0x41-0x46 (uppercase).
REQ-019 UART frame per character: start bit 0, 8 data bits LSB first, one stop bit 1; each bit held exactly CLK_PER_BIT cycles.
REQ-020 State machine states: IDLE, HOLD, START, DATA, STOP.
REQ-021 IDLE -> HOLD on request acceptance.
REQ-022 HOLD behaviour:
  - stays in HOLD while block=1, with tx=1;
  - with block=0, loads character[index] and moves to START on the next edge.
REQ-023 START -> DATA after CLK_PER_BIT cycles.
REQ-024 DATA -> STOP after 8*CLK_PER_BIT cycles.
REQ-025 STOP exit after CLK_PER_BIT cycles:
  - to HOLD with index+1 if index < N-1;
  - otherwise to IDLE.
REQ-026 block is evaluated only in HOLD; a character already started always completes in full.
REQ-027 Latency with block=0: tx falls exactly 1 cycle after the acceptance edge.
REQ-028 Busy duration with block=0 throughout: busy is high for exactly N*(10*CLK_PER_BIT+1) cycles.
REQ-029 Message end: on the edge leaving the last STOP, busy goes 0 and done pulses 1 for one cycle.
REQ-030 A send=1 in the cycle done=1 is accepted, giving back-to-back messages.
REQ-031 A request accepted while block=1 is held in HOLD; busy=1 and tx=1 until block falls.

Reset
REQ-032 rst=1 at any edge forces, on that edge:
  - state IDLE;
  - tx=1, busy=0, done=0;
  - bit/cycle/character counters to 0.
REQ-033 rst takes priority over send.
REQ-034 Reset mid-character aborts the message with no further characters sent; tx is high on the edge following rst.
REQ-035 After reset is released, the first accepted send behaves exactly as REQ-014..REQ-031.

Verification
REQ-036 Scenario: rst=1 for 5 cycles with send=1 -> tx=1, busy=0, done=0 throughout and after release; no start bit.
REQ-037 Scenario: MSG_LEN=4, HEX_MODE=0, TERM=0, block=1, send pulse with data=0x7F1F0701.
  - busy=1 and tx=1 until block drops.
  - Then bytes 0x7F, 0x1F, 0x07, 0x01 are sent LSB first.
  - done pulses after 4*(10*CLK_PER_BIT+1) cycles.
REQ-038 Scenario: HEX_MODE=1, TERM=1, data=0x0F173371.
  - Characters are 0x30,0x46,0x31,0x37,0x33,0x33,0x37,0x31,0x0D,0x0A.
  - 10 characters in total, then done.
REQ-039 Scenario: send pulses and data changed to 0xFFFFFFFF while busy=1 -> original message is sent unchanged and no second message follows.
REQ-040 Scenario: block raised mid-data-bit of character 1.
  - Character 1 completes with a correct stop bit.
  - tx is held high for the block duration.
  - Character 2 starts 1 cycle after block=0.
REQ-041 Scenario: rst pulsed during character 2 -> tx=1 and busy=0 on the next edge; a new send then produces a full correct message.
